// File: rtl/fp_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module   : fp_mul_seq
//  Brief    : Sequential IEEE-754 multiplier for half or single precision.
//             Special operands resolve in one cycle; ordinary operands run a
//             radix-2 shift-add significand multiply, then one normalise
//             cycle and one round-to-nearest-even cycle.
//  Revision : 1.0  initial release
// ============================================================================
module fp_mul_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        MODE_FP,
    input  logic        sign_a,
    input  logic        sign_b,
    input  logic [7:0]  exp_a,
    input  logic [7:0]  exp_b,
    input  logic [22:0] mant_a,
    input  logic [22:0] mant_b,
    input  logic        is_denormal_a,
    input  logic        is_denormal_b,
    output logic [31:0] result,
    output logic [4:0]  flags,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MUL   = 3'd1,
        S_NORM  = 3'd2,
        S_ROUND = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t state_q, state_d;

    // Captured operation context
    logic               mode_q;
    logic               sign_q;
    logic signed [9:0]  exp_q;
    logic [47:0]        mcand_q;
    logic [23:0]        mplier_q;
    logic [47:0]        acc_q;
    logic [4:0]         cnt_q;
    logic [47:0]        norm_q;
    logic [31:0]        result_q;
    logic [4:0]         flags_q;

    // ------------------------------------------------------------------
    // Operand decode from the live inputs (only meaningful in IDLE)
    // ------------------------------------------------------------------
    logic        w_a_exp_zero, w_b_exp_zero;
    logic        w_a_exp_max,  w_b_exp_max;
    logic        w_a_frac_zero, w_b_frac_zero;
    logic        w_a_frac_msb, w_b_frac_msb;
    logic        w_a_impl, w_b_impl;
    logic        w_a_nan, w_b_nan, w_a_snan, w_b_snan;
    logic        w_a_inf, w_b_inf, w_a_zero, w_b_zero;
    logic        w_special;
    logic        w_sign_prod;
    logic [23:0] w_sig_a, w_sig_b;
    logic [9:0]  w_eeff_a, w_eeff_b, w_bias;
    logic [31:0] w_spec_result;
    logic [4:0]  w_spec_flags;

    assign w_a_exp_zero  = MODE_FP ? (exp_a == 8'd0)    : (exp_a[4:0] == 5'd0);
    assign w_b_exp_zero  = MODE_FP ? (exp_b == 8'd0)    : (exp_b[4:0] == 5'd0);
    assign w_a_exp_max   = MODE_FP ? (exp_a == 8'hFF)   : (exp_a[4:0] == 5'h1F);
    assign w_b_exp_max   = MODE_FP ? (exp_b == 8'hFF)   : (exp_b[4:0] == 5'h1F);
    assign w_a_frac_zero = MODE_FP ? (mant_a == 23'd0)  : (mant_a[9:0] == 10'd0);
    assign w_b_frac_zero = MODE_FP ? (mant_b == 23'd0)  : (mant_b[9:0] == 10'd0);
    assign w_a_frac_msb  = MODE_FP ? mant_a[22] : mant_a[9];
    assign w_b_frac_msb  = MODE_FP ? mant_b[22] : mant_b[9];

    assign w_a_nan  = w_a_exp_max & ~w_a_frac_zero;
    assign w_b_nan  = w_b_exp_max & ~w_b_frac_zero;
    assign w_a_snan = w_a_nan & ~w_a_frac_msb;
    assign w_b_snan = w_b_nan & ~w_b_frac_msb;
    assign w_a_inf  = w_a_exp_max & w_a_frac_zero;
    assign w_b_inf  = w_b_exp_max & w_b_frac_zero;
    assign w_a_zero = w_a_exp_zero & w_a_frac_zero;
    assign w_b_zero = w_b_exp_zero & w_b_frac_zero;

    assign w_special   = w_a_nan | w_b_nan | w_a_inf | w_b_inf | w_a_zero | w_b_zero;
    assign w_sign_prod = sign_a ^ sign_b;

    // Denormal (or zero) operands have no hidden one and an effective exponent of 1
    assign w_a_impl = ~(w_a_exp_zero | is_denormal_a);
    assign w_b_impl = ~(w_b_exp_zero | is_denormal_b);
    assign w_sig_a  = MODE_FP ? {w_a_impl, mant_a} : {13'd0, w_a_impl, mant_a[9:0]};
    assign w_sig_b  = MODE_FP ? {w_b_impl, mant_b} : {13'd0, w_b_impl, mant_b[9:0]};
    assign w_eeff_a = ~w_a_impl ? 10'd1 : (MODE_FP ? {2'd0, exp_a} : {5'd0, exp_a[4:0]});
    assign w_eeff_b = ~w_b_impl ? 10'd1 : (MODE_FP ? {2'd0, exp_b} : {5'd0, exp_b[4:0]});
    assign w_bias   = MODE_FP ? 10'd127 : 10'd15;

    // Special-operand result: NaN beats inf*0, which beats inf, which beats zero
    always_comb begin
        w_spec_result = 32'd0;
        w_spec_flags  = 5'd0;
        if (w_a_nan | w_b_nan) begin
            w_spec_result = MODE_FP ? 32'h7FC0_0000 : 32'h0000_7E00;
            w_spec_flags  = {w_a_snan | w_b_snan, 4'd0};
        end else if ((w_a_inf & w_b_zero) | (w_a_zero & w_b_inf)) begin
            w_spec_result = MODE_FP ? 32'h7FC0_0000 : 32'h0000_7E00;
            w_spec_flags  = 5'b10000;
        end else if (w_a_inf | w_b_inf) begin
            w_spec_result = MODE_FP ? {w_sign_prod, 8'hFF, 23'd0}
                                    : {16'd0, w_sign_prod, 5'h1F, 10'd0};
        end else if (w_a_zero | w_b_zero) begin
            w_spec_result = MODE_FP ? {w_sign_prod, 31'd0}
                                    : {16'd0, w_sign_prod, 15'd0};
        end
    end

    // ------------------------------------------------------------------
    // Normalisation: move the product's leading one to bit 47
    // ------------------------------------------------------------------
    logic [5:0]        w_lead;
    logic [47:0]       w_norm;
    logic [9:0]        w_exp_norm;

    // Leading-one position of the raw product, then the matching shift/exponent
    always_comb begin
        w_lead = 6'd0;
        for (int i = 0; i < 48; i++) begin
            if (acc_q[i]) w_lead = 6'(i);
        end
        w_norm     = acc_q << (6'd47 - w_lead);
        // Product of two 1.x values has its binary point at 2*(W-1)
        w_exp_norm = exp_q + {4'd0, w_lead} - (mode_q ? 10'd46 : 10'd20);
    end

    // ------------------------------------------------------------------
    // Rounding: RNE on the W-bit significand held at the top of norm_q
    // ------------------------------------------------------------------
    logic [23:0]        w_mant, w_mant_r;
    logic               w_guard, w_sticky, w_up, w_carry, w_inexact;
    logic signed [9:0]  w_exp_r;
    logic signed [9:0]  w_exp_lim;
    logic [31:0]        w_rnd_result;
    logic [4:0]         w_rnd_flags;

    // Round, detect overflow/underflow and pack the final word
    always_comb begin
        w_mant    = mode_q ? norm_q[47:24] : {13'd0, norm_q[47:37]};
        w_guard   = mode_q ? norm_q[23]    : norm_q[36];
        w_sticky  = mode_q ? (|norm_q[22:0]) : (|norm_q[35:0]);
        w_up      = w_guard & (w_sticky | w_mant[0]);
        w_inexact = w_guard | w_sticky;
        w_mant_r  = w_mant + {23'd0, w_up};
        // A rounding carry clears the hidden-one position (all-ones rolls over)
        w_carry   = mode_q ? ~w_mant_r[23] : ~w_mant_r[10];
        w_exp_r   = exp_q + {9'd0, w_carry};
        w_exp_lim = mode_q ? 10'sd255 : 10'sd31;

        if (w_exp_r >= w_exp_lim) begin
            w_rnd_result = mode_q ? {sign_q, 8'hFF, 23'd0} : {16'd0, sign_q, 5'h1F, 10'd0};
            w_rnd_flags  = 5'b00101;
        end else if (w_exp_r < 10'sd1) begin
            w_rnd_result = mode_q ? {sign_q, 31'd0} : {16'd0, sign_q, 15'd0};
            w_rnd_flags  = 5'b00011;
        end else begin
            w_rnd_result = mode_q ? {sign_q, w_exp_r[7:0], w_mant_r[22:0]}
                                  : {16'd0, sign_q, w_exp_r[4:0], w_mant_r[9:0]};
            w_rnd_flags  = {4'd0, w_inexact};
        end
    end

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    logic [4:0] w_last;
    assign w_last = mode_q ? 5'd23 : 5'd10;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = w_special ? S_DONE : S_MUL;
            S_MUL:   if (cnt_q == w_last) state_d = S_NORM;
            S_NORM:  state_d = S_ROUND;
            S_ROUND: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: capture, shift-add multiply, normalise, round
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q   <= 1'b0;
            sign_q   <= 1'b0;
            exp_q    <= 10'sd0;
            mcand_q  <= 48'd0;
            mplier_q <= 24'd0;
            acc_q    <= 48'd0;
            cnt_q    <= 5'd0;
            norm_q   <= 48'd0;
            result_q <= 32'd0;
            flags_q  <= 5'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mode_q <= MODE_FP;
                        sign_q <= w_sign_prod;
                        if (w_special) begin
                            result_q <= w_spec_result;
                            flags_q  <= w_spec_flags;
                        end else begin
                            mcand_q  <= {24'd0, w_sig_a};
                            mplier_q <= w_sig_b;
                            acc_q    <= 48'd0;
                            cnt_q    <= 5'd0;
                            exp_q    <= w_eeff_a + w_eeff_b - w_bias;
                        end
                    end
                end
                S_MUL: begin
                    if (mplier_q[0]) acc_q <= acc_q + mcand_q;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 5'd1;
                end
                S_NORM: begin
                    norm_q <= w_norm;
                    exp_q  <= w_exp_norm;
                end
                S_ROUND: begin
                    result_q <= w_rnd_result;
                    flags_q  <= w_rnd_flags;
                end
                default: ;
            endcase
        end
    end

    assign result = result_q;
    assign flags  = flags_q;
    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_fp_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fp_mul_seq
//  Brief    : Self-checking bench for fp_mul_seq with an arithmetic model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fp_mul_seq;

    logic        clk = 1'b0;
    logic        rst, start, MODE_FP, sign_a, sign_b;
    logic [7:0]  exp_a, exp_b;
    logic [22:0] mant_a, mant_b;
    logic        is_denormal_a, is_denormal_b;
    logic [31:0] result;
    logic [4:0]  flags;
    logic        busy, done;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fp_mul_seq dut (
        .clk(clk), .rst(rst), .start(start), .MODE_FP(MODE_FP),
        .sign_a(sign_a), .sign_b(sign_b), .exp_a(exp_a), .exp_b(exp_b),
        .mant_a(mant_a), .mant_b(mant_b),
        .is_denormal_a(is_denormal_a), .is_denormal_b(is_denormal_b),
        .result(result), .flags(flags), .busy(busy), .done(done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    endtask

    // Reference: exact integer product, then RNE via remainder comparison
    task automatic ref_mul(input bit mode, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] res, output logic [4:0] fl, output int lat);
        int fb, emax, bias, s, ea, eb, E, L, sh;
        longint fa, fbv, ma, mb, P, m, rem, halfv, one;
        bit nan_a, nan_b, snan_a, snan_b, inf_a, inf_b, zero_a, zero_b, inex, up;
        fb   = mode ? 23 : 10;
        emax = mode ? 255 : 31;
        bias = mode ? 127 : 15;
        one  = 1;
        s    = mode ? int'(a[31] ^ b[31]) : int'(a[15] ^ b[15]);
        ea   = mode ? int'(a[30:23]) : int'(a[14:10]);
        eb   = mode ? int'(b[30:23]) : int'(b[14:10]);
        fa   = mode ? longint'(a[22:0]) : longint'(a[9:0]);
        fbv  = mode ? longint'(b[22:0]) : longint'(b[9:0]);
        nan_a  = (ea == emax) && (fa != 0);
        nan_b  = (eb == emax) && (fbv != 0);
        snan_a = nan_a && (((fa  >> (fb - 1)) & 1) == 0);
        snan_b = nan_b && (((fbv >> (fb - 1)) & 1) == 0);
        inf_a  = (ea == emax) && (fa == 0);
        inf_b  = (eb == emax) && (fbv == 0);
        zero_a = (ea == 0) && (fa == 0);
        zero_b = (eb == 0) && (fbv == 0);
        fl  = 5'd0;
        lat = 1;
        if (nan_a || nan_b) begin
            res = mode ? 32'h7FC00000 : 32'h00007E00;
            fl  = (snan_a || snan_b) ? 5'b10000 : 5'b00000;
        end else if ((inf_a && zero_b) || (zero_a && inf_b)) begin
            res = mode ? 32'h7FC00000 : 32'h00007E00;
            fl  = 5'b10000;
        end else if (inf_a || inf_b) begin
            res = mode ? ((32'(s) << 31) | 32'h7F800000) : ((32'(s) << 15) | 32'h7C00);
        end else if (zero_a || zero_b) begin
            res = mode ? (32'(s) << 31) : (32'(s) << 15);
        end else begin
            lat = mode ? 27 : 14;
            ma = ((ea == 0) ? 0 : (one << fb)) | fa;
            mb = ((eb == 0) ? 0 : (one << fb)) | fbv;
            if (ea == 0) ea = 1;
            if (eb == 0) eb = 1;
            P = ma * mb;
            L = 0;
            for (int i = 0; i < 63; i++) if (P[i]) L = i;
            E  = ea + eb - bias + L - 2 * fb;
            sh = L - fb;
            inex = 1'b0;
            up   = 1'b0;
            if (sh > 0) begin
                m     = P >> sh;
                rem   = P - (m << sh);
                halfv = one << (sh - 1);
                up    = (rem > halfv) || ((rem == halfv) && m[0]);
                inex  = (rem != 0);
            end else begin
                m = P << (-sh);
            end
            if (up) m = m + 1;
            if (m == (one << (fb + 1))) begin
                m = m >> 1;
                E = E + 1;
            end
            if (E >= emax) begin
                res = mode ? ((32'(s) << 31) | 32'h7F800000) : ((32'(s) << 15) | 32'h7C00);
                fl  = 5'b00101;
            end else if (E < 1) begin
                res = mode ? (32'(s) << 31) : (32'(s) << 15);
                fl  = 5'b00011;
            end else begin
                m   = m & ((one << fb) - 1);
                res = mode ? ((32'(s) << 31) | (32'(E) << 23) | 32'(m))
                           : ((32'(s) << 15) | (32'(E) << 10) | 32'(m));
                fl  = {4'd0, inex};
            end
        end
    endtask

    task automatic drive_ops(input bit mode, input logic [31:0] a, input logic [31:0] b);
        MODE_FP = mode;
        if (mode) begin
            sign_a = a[31]; exp_a = a[30:23]; mant_a = a[22:0];
            sign_b = b[31]; exp_b = b[30:23]; mant_b = b[22:0];
        end else begin
            sign_a = a[15]; exp_a = {3'd0, a[14:10]}; mant_a = {13'd0, a[9:0]};
            sign_b = b[15]; exp_b = {3'd0, b[14:10]}; mant_b = {13'd0, b[9:0]};
        end
        is_denormal_a = (exp_a == 8'd0) && (mant_a != 23'd0);
        is_denormal_b = (exp_b == 8'd0) && (mant_b != 23'd0);
    endtask

    task automatic scramble();
        drive_ops(1'($urandom), $urandom, $urandom);
    endtask

    function automatic logic [31:0] gen_operand(input bit mode);
        int sel, e;
        logic [31:0] f, s;
        sel = $urandom_range(0, 11);
        s   = 32'($urandom_range(0, 1));
        if (mode) begin
            case (sel)
                0: e = 0;
                1: e = 255;
                2: e = $urandom_range(1, 4);
                3: e = $urandom_range(250, 254);
                default: e = $urandom_range(90, 164);
            endcase
            f = $urandom & 32'h7FFFFF;
            if ($urandom_range(0, 3) == 0) f = 0;
            return (s << 31) | (32'(e) << 23) | f;
        end else begin
            case (sel)
                0: e = 0;
                1: e = 31;
                2: e = $urandom_range(1, 3);
                3: e = $urandom_range(28, 30);
                default: e = $urandom_range(8, 22);
            endcase
            f = $urandom & 32'h3FF;
            if ($urandom_range(0, 3) == 0) f = 0;
            return (s << 15) | (32'(e) << 10) | f;
        end
    endfunction

    // One complete operation: latency, busy span, result, flags, hold after done
    task automatic run_op(input string tag, input bit mode, input logic [31:0] a,
                          input logic [31:0] b, output logic [31:0] got_res,
                          output logic [4:0] got_fl);
        logic [31:0] eres;
        logic [4:0]  efl;
        int          elat, n;
        bit          busy_ok;
        ref_mul(mode, a, b, eres, efl, elat);
        @(negedge clk);
        drive_ops(mode, a, b);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        scramble();
        n = 1;
        busy_ok = 1'b1;
        while (!done && n < 40) begin
            if (!busy) busy_ok = 1'b0;
            start = 1'($urandom);
            scramble();
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        got_res = result;
        got_fl  = flags;
        check_eq({tag, " latency"}, 32'(n), 32'(elat));
        check_eq({tag, " busy"}, {31'd0, busy_ok & busy}, 32'd1);
        check_eq({tag, " result"}, result, eres);
        check_eq({tag, " flags"}, {27'd0, flags}, {27'd0, efl});
        @(posedge clk); #1;
        check_eq({tag, " done pulse"}, {30'd0, done, busy}, 32'd0);
        check_eq({tag, " result held"}, result, eres);
    endtask

    initial begin
        logic [31:0] r;
        logic [4:0]  f;
        int          dones;
        rst = 1'b1; start = 1'b0;
        drive_ops(1'b1, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset result", result, 32'd0);
        check_eq("reset flags busy done", {25'd0, flags, busy, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("sgl 1.5x2", 1'b1, 32'h3FC00000, 32'h40000000, r, f);
        check_eq("sgl 1.5x2 const", r, 32'h40400000);
        run_op("half 1x1", 1'b0, 32'h3C00, 32'h3C00, r, f);
        check_eq("half 1x1 const", r, 32'h00003C00);
        run_op("inf x 0", 1'b1, 32'h7F800000, 32'h00000000, r, f);
        check_eq("inf x 0 const", {f, r[26:0]}, {5'b10000, 27'h7C00000});
        run_op("ovf", 1'b1, 32'h7F000000, 32'h7F000000, r, f);
        check_eq("ovf const", {f, r[26:0]}, {5'b00101, 27'h7800000});
        run_op("unf", 1'b1, 32'h00800000, 32'h3F000000, r, f);
        check_eq("unf const", {f, r[26:0]}, {5'b00011, 27'h0});
        run_op("denorm", 1'b1, 32'h00000003, 32'h7E800001, r, f);
        run_op("half snan", 1'b0, 32'h7C01, 32'h3C00, r, f);
        run_op("half tie", 1'b0, 32'h3C01, 32'h3800, r, f);

        // Reset in the middle of a single-precision multiply
        @(negedge clk);
        drive_ops(1'b1, 32'h3FC00000, 32'h40000000);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        check_eq("midrst result", result, 32'd0);
        check_eq("midrst flags busy done", {25'd0, flags, busy, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        dones = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done || busy) dones++;
        end
        check_eq("midrst quiet", 32'(dones), 32'd0);
        run_op("after rst", 1'b1, 32'h3FC00000, 32'h40000000, r, f);

        for (int i = 0; i < 160; i++) begin
            bit m;
            m = 1'($urandom);
            run_op($sformatf("rand%0d", i), m, gen_operand(m), gen_operand(m), r, f);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fp_mul_seq.md
FP_MUL_SEQ -- requirements
Module: fp_mul_seq

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port start, input, 1, request to multiply the presented operands; sampled only in IDLE.
REQ-004 SHALL have port MODE_FP, input, 1, 0 = half, 1 = single; captured with start.
REQ-005 SHALL have ports sign_a / sign_b, input, 1 each, operand signs.
REQ-006 SHALL have ports exp_a / exp_b, input, 8 each, biased exponents; half values in bits [4:0], upper bits zero.
REQ-007 SHALL have ports mant_a / mant_b, input, 23 each, stored fractions; half values in bits [9:0], upper bits zero.
REQ-008 SHALL have ports is_denormal_a / is_denormal_b, input, 1 each, exponent zero with nonzero fraction.
REQ-009 SHALL have port result, output, 32, packed product; half results in [15:0] with [31:16] = 0.
REQ-010 SHALL have port flags, output, 5, {invalid, divzero, overflow, underflow, inexact}; divzero is always 0.
REQ-011 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-012 SHALL have port done, output, 1, one-cycle pulse when result/flags are valid.

Function
REQ-013 SHALL implement states IDLE, MUL, NORM, ROUND, DONE; DONE always returns to IDLE after one cycle.
REQ-014 SHALL, when start is sampled in IDLE at edge k, capture all operand inputs and MODE_FP; later input changes SHALL have no effect.
REQ-015 SHALL ignore start when not in IDLE; no queuing.
REQ-016 SHALL use width W = 24 (single) or 11 (half) and bias 127 or 15; the significand is {implicit, fraction}, with implicit = 0 and effective exponent 1 for denormal or zero operands.
REQ-017 SHALL detect special cases in IDLE: a NaN operand, or inf×0, gives canonical qNaN (single 0x7FC00000, half 0x00007E00); an inf operand otherwise gives signed inf; a zero operand otherwise gives signed zero; special cases SHALL go IDLE→DONE, so done is high in cycle k+1.
REQ-018 SHALL set invalid for inf×0 or a signalling NaN input (fraction MSB = 0); other special cases SHALL produce flags = 0.
REQ-019 SHALL, for normal cases, run MUL for exactly W cycles as a radix-2 shift-add over a 2W-bit product register (one multiplier bit per cycle).
REQ-020 SHALL hold NORM for 1 cycle: normalize the leading one to the top position (left shifts for denormal inputs); exponent math is 10-bit signed (ea + eb − bias + adjust).
REQ-021 SHALL hold ROUND for 1 cycle: round to nearest, ties to even, using guard and sticky bits; a mantissa carry-out increments the exponent.
REQ-022 SHALL produce signed inf with flags overflow|inexact when the rounded exponent ≥ 255 (single) or ≥ 31 (half).
REQ-023 SHALL flush to signed zero with flags underflow|inexact when the rounded exponent < 1; no denormal outputs are produced.
REQ-024 SHALL set inexact when any discarded product bit is nonzero.
REQ-025 SHALL have a normal-case latency of done high in cycle k+W+3 (single 27, half 14).
REQ-026 SHALL hold result and flags stable from done until the next accepted start; result sign is always sign_a XOR sign_b, except for NaN.

Reset
REQ-027 SHALL, on rst high at any edge (including mid-operation), enter IDLE with result = 0, flags = 0, busy = 0, done = 0, discarding any operation in flight.
REQ-028 SHALL accept no start in the same cycle rst is high.

Verification
REQ-029 SHALL pass: single 0x3FC00000 × 0x40000000 → result 0x40400000, flags 0, done at k+27, busy high k+1..k+27.
REQ-030 SHALL pass: half 0x3C00 × 0x3C00 → result 0x00003C00, flags 0, done at k+14.
REQ-031 SHALL pass: single +inf (0x7F800000) × +0 → 0x7FC00000, flags 5'b10000, done at k+1.
REQ-032 SHALL pass: single 0x7F000000 × 0x7F000000 → 0x7F800000, flags 5'b00101.
REQ-033 SHALL pass: single 0x00800000 × 0x3F000000 → 0x00000000, flags 5'b00011.
REQ-034 SHALL pass: rst asserted at k+10 of a single op → IDLE next cycle, no done pulse, outputs 0; a following start completes normally.
